// File: rtl/lcd_cmd_sched.sv
// Host-side command sequencer for the LCD controller: queues host commands, issues them
// over the cmd/valid/busy handshake, streams the image ROM during LOAD, checks pixel counts.
module lcd_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int IMG_WORDS  = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_host_cmd,
  input  logic       i_host_valid,
  output logic       o_host_ready,
  output logic [2:0] o_lcd_cmd,
  output logic       o_lcd_cmd_valid,
  input  logic       i_lcd_busy,
  input  logic       i_lcd_output_valid,
  output logic [7:0] o_lcd_datain,
  output logic [$clog2(IMG_WORDS)-1:0] o_img_addr,
  input  logic [7:0] i_img_rdata,
  output logic       o_cmd_done,
  output logic       o_pix_err,
  output logic       o_timeout_err,
  output logic       o_idle
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = $clog2(IMG_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IMG_WORDS - 1);
  localparam logic [7:0]        TMO_LIM  = 8'(TIMEOUT);
  localparam logic [2:0]        CMD_LOAD = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_timeout;
  logic              w_run_end;
  logic              w_pix_window;

  logic [2:0]        r_lcd_cmd;
  logic [ADDR_W-1:0] r_img_addr;
  logic [7:0]        r_tmo_cnt;
  logic [4:0]        r_pix_cnt;
  logic              r_cmd_done;
  logic              r_pix_err;
  logic              r_timeout_err;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push       = i_host_valid && !w_full;
  assign w_pix_window = (r_state == S_WAIT_BUSY) || (r_state == S_RUN) || (r_state == S_DONE);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_timeout    = 1'b0;
    w_run_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !i_lcd_busy) begin
          w_state_next = S_ISSUE;
          w_pop        = 1'b1;
        end
      end
      S_ISSUE: w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_lcd_busy) begin
          w_state_next = S_RUN;
        end else if (r_tmo_cnt == TMO_LIM) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end
      end
      S_RUN: begin
        if (!i_lcd_busy) begin
          w_state_next = S_DONE;
          w_run_end    = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_host_cmd;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_lcd_cmd     <= 3'd0;
      r_img_addr    <= '0;
      r_tmo_cnt     <= 8'd0;
      r_pix_cnt     <= 5'd0;
      r_cmd_done    <= 1'b0;
      r_pix_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_lcd_cmd <= r_fifo[r_rd_ptr];
        r_pix_cnt <= 5'd0;
        if (r_fifo[r_rd_ptr] == CMD_LOAD) r_img_addr <= '0;
      end else if (w_pix_window && i_lcd_output_valid && (r_pix_cnt != 5'd31)) begin
        r_pix_cnt <= r_pix_cnt + 5'd1;
      end

      if (r_state == S_ISSUE) begin
        r_tmo_cnt <= 8'd0;
      end else if ((r_state == S_WAIT_BUSY) && !i_lcd_busy && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end

      // Address 0 is presented on the first RUN cycle; advance afterwards and hold at the last word.
      if ((r_state == S_RUN) && i_lcd_busy && (r_lcd_cmd == CMD_LOAD) && (r_img_addr != ADDR_MAX)) begin
        r_img_addr <= r_img_addr + ADDR_W'(1);
      end

      r_cmd_done <= w_timeout || w_run_end;
      if (w_timeout) r_timeout_err <= 1'b1;
      if ((r_state == S_DONE) && (r_pix_cnt != 5'd16)) r_pix_err <= 1'b1;
    end
  end

  assign o_host_ready    = !w_full;
  assign o_lcd_cmd       = r_lcd_cmd;
  assign o_lcd_cmd_valid = (r_state == S_ISSUE);
  assign o_lcd_datain    = i_img_rdata;
  assign o_img_addr      = r_img_addr;
  assign o_cmd_done      = r_cmd_done;
  assign o_pix_err       = r_pix_err;
  assign o_timeout_err   = r_timeout_err;
  assign o_idle          = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scoreboard bench for lcd_cmd_sched: stimulus queues expected strobes/completions/bytes,
// an LCD model and a monitor pop and compare them as the DUT produces them.
module tb_lcd_cmd_sched;
  localparam int TMO = 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] host_cmd   = 3'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_output_valid;
  logic [7:0] lcd_datain;
  logic [5:0] img_addr;
  logic [7:0] img_rdata;
  logic       cmd_done;
  logic       pix_err;
  logic       timeout_err;
  logic       idle;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic model_ov   = 1'b0;
  logic rnd_ov     = 1'b0;
  logic [7:0] rom [64];

  assign lcd_busy         = model_busy | force_busy;
  assign lcd_output_valid = model_ov | rnd_ov;
  assign img_rdata        = rom[img_addr];

  lcd_cmd_sched dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_host_cmd         (host_cmd),
    .i_host_valid       (host_valid),
    .o_host_ready       (host_ready),
    .o_lcd_cmd          (lcd_cmd),
    .o_lcd_cmd_valid    (lcd_cmd_valid),
    .i_lcd_busy         (lcd_busy),
    .i_lcd_output_valid (lcd_output_valid),
    .o_lcd_datain       (lcd_datain),
    .o_img_addr         (img_addr),
    .i_img_rdata        (img_rdata),
    .o_cmd_done         (cmd_done),
    .o_pix_err          (pix_err),
    .o_timeout_err      (timeout_err),
    .o_idle             (idle)
  );

  always #5 clk = ~clk;

  typedef struct { bit resp; int len; int npix; bit load; } cfg_t;
  typedef struct { bit tmo; bit pix; int lat; } done_t;

  cfg_t       cfg_q[$];
  logic [2:0] cmd_q[$];
  done_t      done_q[$];
  logic [7:0] cap_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // LCD controller model: busy from the cycle after a strobe for cfg.len cycles,
  // pixel strobes and image capture from the second busy cycle on.
  int busy_left = 0;
  int busy_cyc  = 0;
  int pix_left  = 0;
  bit is_load   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_left  = 0;
      model_busy = 1'b0;
      model_ov   = 1'b0;
    end else begin
      if (busy_left > 0) begin
        model_busy = 1'b1;
        busy_cyc++;
        busy_left--;
        model_ov = (busy_cyc >= 2) && (pix_left > 0);
        if (model_ov) pix_left--;
        if (is_load && busy_cyc >= 2 && busy_cyc <= 65 && cap_q.size() > 0) begin
          logic [7:0] eb;
          eb = cap_q.pop_front();
          chk($sformatf("load_byte_%0d", busy_cyc - 2), int'(lcd_datain), int'(eb));
        end
      end else begin
        model_busy = 1'b0;
        model_ov   = 1'b0;
      end
      if (lcd_cmd_valid && cfg_q.size() > 0) begin
        cfg_t c;
        c = cfg_q.pop_front();
        if (c.resp) begin
          busy_left = c.len;
          busy_cyc  = 0;
          pix_left  = c.npix;
          is_load   = c.load;
        end
      end
    end
  end

  // Monitor: compares each strobe and each completion against the scoreboard.
  int strobe_cyc = 0;
  bit pix_pend   = 1'b0;
  bit pix_exp    = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_pend = 1'b0;
    end else begin
      if (pix_pend) begin
        chk("pix_err_after_done", int'(pix_err), int'(pix_exp));
        pix_pend = 1'b0;
      end
      if (lcd_cmd_valid) begin
        strobe_cyc = cyc;
        if (cmd_q.size() == 0) begin
          chk("unexpected_strobe", int'(lcd_cmd_valid), 0);
        end else begin
          logic [2:0] ec;
          ec = cmd_q.pop_front();
          $display("strobe cyc=%0d cmd=%0d expected=%0d", cyc, lcd_cmd, ec);
          chk("lcd_cmd", int'(lcd_cmd), int'(ec));
        end
      end
      if (cmd_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", int'(cmd_done), 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          $display("done cyc=%0d latency=%0d timeout_err=%0b", cyc, cyc - strobe_cyc - 1, timeout_err);
          chk("timeout_err_at_done", int'(timeout_err), int'(d.tmo));
          chk("done_latency", cyc - strobe_cyc - 1, d.lat);
          pix_pend = 1'b1;
          pix_exp  = d.pix;
        end
      end
    end
  end

  task automatic push(input logic [2:0] cmd, input bit acc, input bit resp, input int len,
                      input int npix, input bit tmo_after, input bit pix_after);
    @(negedge clk);
    chk($sformatf("host_ready_before_push_%0d", cmd), int'(host_ready), int'(acc));
    host_valid = 1'b1;
    host_cmd   = cmd;
    if (acc) begin
      cmd_q.push_back(cmd);
      cfg_q.push_back('{resp: resp, len: len, npix: npix, load: (cmd == 3'd1)});
      done_q.push_back('{tmo: tmo_after, pix: pix_after, lat: resp ? len + 1 : TMO + 1});
    end
    @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      n++;
      ok = idle && (cmd_q.size() == 0) && (done_q.size() == 0) && (busy_left == 0) && !pix_pend;
    end
    chk({name, "_drained"}, int'(ok), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_host_ready"},    int'(host_ready), 1);
    chk({tag, "_lcd_cmd"},       int'(lcd_cmd), 0);
    chk({tag, "_lcd_cmd_valid"}, int'(lcd_cmd_valid), 0);
    chk({tag, "_img_addr"},      int'(img_addr), 0);
    chk({tag, "_cmd_done"},      int'(cmd_done), 0);
    chk({tag, "_pix_err"},       int'(pix_err), 0);
    chk({tag, "_timeout_err"},   int'(timeout_err), 0);
    chk({tag, "_idle"},          int'(idle), 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'(i * 3);

    // Reset held with random inputs
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      host_valid = 1'($urandom_range(0, 1));
      host_cmd   = 3'($urandom_range(0, 7));
      force_busy = 1'($urandom_range(0, 1));
      rnd_ov     = 1'($urandom_range(0, 1));
      #1 chk_reset_vals($sformatf("reset%0d", k));
    end
    @(negedge clk);
    host_valid = 1'b0;
    force_busy = 1'b0;
    rnd_ov     = 1'b0;
    rst_n      = 1'b1;

    // REFRESH with 16 pixels
    push(3'd0, 1'b1, 1'b1, 17, 16, 1'b0, 1'b0);
    wait_idle("refresh");

    // LOAD streams ROM bytes 0,3,..,189
    for (int i = 0; i < 64; i++) cap_q.push_back(8'(i * 3));
    push(3'd1, 1'b1, 1'b1, 66, 16, 1'b0, 1'b0);
    wait_idle("load");
    chk("img_addr_saturated", int'(img_addr), 63);

    // Backpressure: LCD held busy, fifth push dropped
    @(negedge clk);
    force_busy = 1'b1;
    push(3'd2, 1'b1, 1'b1, 17, 16, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, 17, 16, 1'b0, 1'b0);
    push(3'd6, 1'b1, 1'b1, 17, 16, 1'b0, 1'b0);
    push(3'd7, 1'b1, 1'b1, 17, 16, 1'b0, 1'b0);
    push(3'd5, 1'b0, 1'b1, 17, 16, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("host_ready_while_full", int'(host_ready), 0);
    chk("idle_while_full", int'(idle), 0);
    force_busy = 1'b0;
    wait_idle("backpressure");

    // Timeout, then the next queued command still goes out
    push(3'd4, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    push(3'd0, 1'b1, 1'b1, 17, 16, 1'b1, 1'b0);
    wait_idle("timeout");

    // Pixel error is sticky across a later good command
    push(3'd6, 1'b1, 1'b1, 17, 15, 1'b1, 1'b1);
    push(3'd7, 1'b1, 1'b1, 17, 16, 1'b1, 1'b1);
    wait_idle("pixerr");
    chk("pix_err_sticky", int'(pix_err), 1);
    chk("timeout_err_sticky", int'(timeout_err), 1);

    // Only reset clears the sticky errors
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_vals("final_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_strobe_after_reset", int'(lcd_cmd_valid), 0);
    chk("cmd_q_left", cmd_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("cap_q_left", cap_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
